init_reset_sequencer: RTL and testbench
=======================================

INIT_RESET_SEQUENCER -- requirements
Module: init_reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for asynchronous status inputs, legal range 2..4.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: cycles all qualifiers must stay high before PERIPH_RESET_N releases, legal range 1..65535.
REQ-003 SHALL have parameter STAGE_GAP, default 8: cycles between PERIPH_RESET_N release and FABRIC_RESET_N release, legal range 1..65535.
REQ-004 SHALL have port CLK, input, 1, sole clock; all sequential logic rising-edge.
REQ-005 SHALL have port RESETN, input, 1, asynchronous active-low reset, driven from FABRIC_POR_N.
REQ-006 SHALL have port DEVICE_INIT_DONE, input, 1, device init complete, asynchronous.
REQ-007 SHALL have port XCVR_INIT_DONE, input, 1, transceiver init complete, asynchronous.
REQ-008 SHALL have port PLL_LOCK, input, 1, fabric PLL lock, asynchronous.
REQ-009 SHALL have port EXT_RST_N, input, 1, external active-low reset request, asynchronous.
REQ-010 SHALL have port PERIPH_RESET_N, output, 1, first-stage active-low reset.
REQ-011 SHALL have port FABRIC_RESET_N, output, 1, second-stage active-low reset.
REQ-012 SHALL have port INIT_READY, output, 1, high only in RUN.
REQ-013 SHALL have port DROP_COUNT, output, 8, saturating count of qualifier drops after leaving IDLE.

Function
REQ-014 SHALL pass each asynchronous input through its own SYNC_STAGES-flop synchronizer; qual = AND of the four synchronized values.
REQ-015 SHALL implement states IDLE, HOLD, PERIPH, RUN; all outputs registered and decoded from state.
REQ-016 IDLE: both resets low, INIT_READY low; on an edge with qual=1, SHALL go to HOLD and clear the 16-bit counter.
REQ-017 HOLD: counter increments each cycle; on an edge with qual=1 and counter=HOLD_CYCLES-1, SHALL go to PERIPH and clear the counter.
REQ-018 PERIPH: PERIPH_RESET_N high; on an edge with qual=1 and counter=STAGE_GAP-1, SHALL go to RUN.
REQ-019 RUN: both resets high, INIT_READY high; SHALL remain in RUN while qual=1.
REQ-020 In HOLD, PERIPH or RUN, an edge with qual=0 SHALL go to IDLE, clear the counter and increment DROP_COUNT; all outputs low after that same edge.
REQ-021 DROP_COUNT SHALL saturate at 255 and never wrap.
REQ-022 Latency: with raw inputs high before edge 1, qual is seen at edge SYNC_STAGES+1; PERIPH_RESET_N rises at edge SYNC_STAGES+1+HOLD_CYCLES; FABRIC_RESET_N rises STAGE_GAP edges later. Defaults give edges 19 and 27.
REQ-023 FABRIC_RESET_N SHALL never be high while PERIPH_RESET_N is low.
REQ-024 A qual glitch shorter than one cycle after synchronization SHALL restart the full HOLD_CYCLES window; the window is never partially credited.

Reset
REQ-025 RESETN low SHALL asynchronously force state IDLE, counter 0, DROP_COUNT 0, all synchronizer flops 0, PERIPH_RESET_N=0, FABRIC_RESET_N=0, INIT_READY=0.
REQ-026 Reset assertion mid-sequence, including in RUN, SHALL drive both reset outputs low without waiting for a clock edge; deassertion SHALL restart from IDLE.

Structure
REQ-027 Shared package init_seq_pkg SHALL hold the state enum, counter width (16) and parameter defaults.
REQ-028 One sub-module, init_sync_cell: a parameterized-depth single-bit synchronizer with asynchronous active-low clear, instantiated four times.

Verification
REQ-029 Defaults, all inputs high from reset release -> PERIPH_RESET_N rises at edge 19, FABRIC_RESET_N and INIT_READY rise at edge 27, DROP_COUNT=0.
REQ-030 PLL_LOCK low for 3 cycles mid-HOLD (counter=10) -> return to IDLE, DROP_COUNT=1, full 16-cycle HOLD repeated after relock.
REQ-031 EXT_RST_N pulled low in RUN -> both resets low 3 edges later (2 sync + 1 register), INIT_READY low, DROP_COUNT increments.
REQ-032 Forced drops 300 times -> DROP_COUNT holds at 255.
REQ-033 RESETN asserted during PERIPH -> outputs low immediately, without a clock edge; DROP_COUNT=0; normal sequence resumes after release.
REQ-034 HOLD_CYCLES=1, STAGE_GAP=1 -> PERIPH_RESET_N at edge 4, FABRIC_RESET_N at edge 5; assertion checks REQ-023 throughout all tests.

Source files
------------

// File: rtl/init_seq_pkg.sv
// Shared state encoding, counter width and parameter defaults for the init/reset sequencer.
package init_seq_pkg;

    localparam int CNT_W           = 16;
    localparam int DROP_W          = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_STAGE_GAP   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_PERIPH = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

endpackage

// File: rtl/init_sync_cell.sv
// Single-bit multi-flop synchronizer with asynchronous active-low clear.
module init_sync_cell #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/init_reset_sequencer.sv
// Two-stage reset release sequencer gated by synchronized init/lock qualifiers.
//   state     | meaning
//   ST_IDLE   | all resets asserted, waiting for qual
//   ST_HOLD   | qual stable, counting HOLD_CYCLES before peripheral release
//   ST_PERIPH | peripheral reset released, counting STAGE_GAP before fabric release
//   ST_RUN    | both resets released, INIT_READY high
module init_reset_sequencer
    import init_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGE_GAP   = DEF_STAGE_GAP
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              DEVICE_INIT_DONE,
    input  logic              XCVR_INIT_DONE,
    input  logic              PLL_LOCK,
    input  logic              EXT_RST_N,
    output logic              PERIPH_RESET_N,
    output logic              FABRIC_RESET_N,
    output logic              INIT_READY,
    output logic [DROP_W-1:0] DROP_COUNT
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    logic [3:0] raw_async;
    logic [3:0] sync_s;
    logic       qual;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                periph_q, periph_d;
    logic                fabric_q, fabric_d;
    logic                ready_q, ready_d;

    assign raw_async = {DEVICE_INIT_DONE, XCVR_INIT_DONE, PLL_LOCK, EXT_RST_N};

    for (genvar i = 0; i < 4; i++) begin : g_sync
        init_sync_cell #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i  (CLK),
            .rst_n_i(RESETN),
            .d_i    (raw_async[i]),
            .q_o    (sync_s[i])
        );
    end

    assign qual = &sync_s;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            drop_q   <= '0;
            periph_q <= 1'b0;
            fabric_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
            periph_q <= periph_d;
            fabric_q <= fabric_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;

        unique case (state_q)
            ST_IDLE: begin
                if (qual) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (qual && cnt_q == HOLD_LAST) begin
                    state_d = ST_PERIPH;
                    cnt_d   = '0;
                end else if (qual) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PERIPH: begin
                if (qual && cnt_q == GAP_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (qual) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Any qualifier loss outside IDLE aborts the sequence; the hold window restarts from zero.
        if (!qual && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            drop_d  = (drop_q == '1) ? drop_q : drop_q + DROP_W'(1);
        end
    end

    // Outputs decode the next state so they change on the same edge as the state register.
    always_comb begin
        periph_d = (state_d == ST_PERIPH) || (state_d == ST_RUN);
        fabric_d = (state_d == ST_RUN);
        ready_d  = (state_d == ST_RUN);
    end

    assign PERIPH_RESET_N = periph_q;
    assign FABRIC_RESET_N = fabric_q;
    assign INIT_READY     = ready_q;
    assign DROP_COUNT     = drop_q;

endmodule

// File: tb/tb_init_reset_sequencer.sv
// Scoreboard bench: a run-length reference model predicts outputs per edge, a negedge monitor compares.
module tb_init_reset_sequencer;

    localparam int SYNC = 2;

    logic       clk, resetn, dev, xcvr, pll, ext;
    logic       pa, fa, ra, pb, fb, rb;
    logic [7:0] da, db;

    init_reset_sequencer #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(16), .STAGE_GAP(8)) dut_a (
        .CLK(clk), .RESETN(resetn), .DEVICE_INIT_DONE(dev), .XCVR_INIT_DONE(xcvr),
        .PLL_LOCK(pll), .EXT_RST_N(ext), .PERIPH_RESET_N(pa), .FABRIC_RESET_N(fa),
        .INIT_READY(ra), .DROP_COUNT(da)
    );

    init_reset_sequencer #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(1), .STAGE_GAP(1)) dut_b (
        .CLK(clk), .RESETN(resetn), .DEVICE_INIT_DONE(dev), .XCVR_INIT_DONE(xcvr),
        .PLL_LOCK(pll), .EXT_RST_N(ext), .PERIPH_RESET_N(pb), .FABRIC_RESET_N(fb),
        .INIT_READY(rb), .DROP_COUNT(db)
    );

    typedef struct packed {
        logic       p;
        logic       f;
        logic       r;
        logic [7:0] d;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    bit   hist[$];
    bit   qs;
    int   run_len, drop_m, edge_cnt;
    int   n_cmp = 0;
    int   n_err = 0;
    int   rise_pa, rise_fa, rise_ra, rise_pb, rise_fb, fall_fa;
    int   ext_edge;
    logic prev_pa, prev_fa, prev_ra, prev_pb, prev_fb;
    exp_t ea, eb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d (edge %0d)", name, act, exp_v, edge_cnt);
        end
    endtask

    // Sequence position is just the length of the current unbroken run of qual=1 edges.
    function automatic exp_t expect_out(input int r, input int hold, input int gap, input int d);
        exp_t e;
        e.p = (r > hold);
        e.f = (r > hold + gap);
        e.r = e.f;
        e.d = d[7:0];
        return e;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            hist.delete();
            for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
            run_len  = 0;
            drop_m   = 0;
            edge_cnt = 0;
            exp_a.delete();
            exp_b.delete();
        end else begin
            qs = hist.pop_front();
            hist.push_back(dev & xcvr & pll & ext);
            edge_cnt++;
            if (qs) begin
                run_len++;
            end else begin
                if (run_len > 0 && drop_m < 255) drop_m++;
                run_len = 0;
            end
            exp_a.push_back(expect_out(run_len, 16, 8, drop_m));
            exp_b.push_back(expect_out(run_len, 1, 1, drop_m));
        end
    end

    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_periph_a", int'(pa), 0);
            chk("rst_fabric_a", int'(fa), 0);
            chk("rst_ready_a",  int'(ra), 0);
            chk("rst_drop_a",   int'(da), 0);
            chk("rst_periph_b", int'(pb), 0);
            chk("rst_drop_b",   int'(db), 0);
        end else if (exp_a.size() == 0 || exp_b.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: actual empty required entry (edge %0d)", edge_cnt);
        end else begin
            ea = exp_a.pop_front();
            eb = exp_b.pop_front();
            chk("periph_a", int'(pa), int'(ea.p));
            chk("fabric_a", int'(fa), int'(ea.f));
            chk("ready_a",  int'(ra), int'(ea.r));
            chk("drop_a",   int'(da), int'(ea.d));
            chk("periph_b", int'(pb), int'(eb.p));
            chk("fabric_b", int'(fb), int'(eb.f));
            chk("ready_b",  int'(rb), int'(eb.r));
            chk("drop_b",   int'(db), int'(eb.d));
            if (pa && !prev_pa) rise_pa = edge_cnt;
            if (fa && !prev_fa) rise_fa = edge_cnt;
            if (ra && !prev_ra) rise_ra = edge_cnt;
            if (pb && !prev_pb) rise_pb = edge_cnt;
            if (fb && !prev_fb) rise_fb = edge_cnt;
            if (!fa && prev_fa) fall_fa = edge_cnt;
        end
        chk("order_a", int'(fa & ~pa), 0);
        chk("order_b", int'(fb & ~pb), 0);
        prev_pa = pa;
        prev_fa = fa;
        prev_ra = ra;
        prev_pb = pb;
        prev_fb = fb;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic apply_reset(input int hold);
        resetn = 1'b0;
        #1;
        chk("async_periph_a", int'(pa), 0);
        chk("async_fabric_a", int'(fa), 0);
        chk("async_ready_a",  int'(ra), 0);
        chk("async_drop_a",   int'(da), 0);
        chk("async_periph_b", int'(pb), 0);
        chk("async_fabric_b", int'(fb), 0);
        step(hold);
        resetn = 1'b1;
    endtask

    initial begin
        int len, mode;
        resetn = 1'b1;
        dev = 1'b1; xcvr = 1'b1; pll = 1'b1; ext = 1'b1;
        prev_pa = 0; prev_fa = 0; prev_ra = 0; prev_pb = 0; prev_fb = 0;
        rise_pa = -1; rise_fa = -1; rise_ra = -1; rise_pb = -1; rise_fb = -1; fall_fa = -1;
        #1 resetn = 1'b0;
        step(3);
        resetn = 1'b1;

        // Clean power-up with all qualifiers high.
        step(32);
        chk("lat_periph_a", rise_pa, 19);
        chk("lat_fabric_a", rise_fa, 27);
        chk("lat_ready_a",  rise_ra, 27);
        chk("lat_periph_b", rise_pb, 4);
        chk("lat_fabric_b", rise_fb, 5);
        chk("lat_drop_a",   int'(da), 0);

        // PLL unlock for 3 cycles while dut_a counter is 10.
        apply_reset(2);
        step(13);
        pll = 1'b0;
        step(3);
        pll = 1'b1;
        step(40);
        chk("relock_periph_a", rise_pa, 35);
        chk("relock_fabric_a", rise_fa, 43);
        chk("relock_drop_a",   int'(da), 1);
        chk("relock_drop_b",   int'(db), 1);

        // External reset request while running.
        chk("ext_pre_ready_a", int'(ra), 1);
        ext_edge = edge_cnt;
        ext = 1'b0;
        step(5);
        chk("ext_fall_lat", fall_fa - ext_edge, 3);
        chk("ext_ready_a",  int'(ra), 0);
        chk("ext_periph_a", int'(pa), 0);
        chk("ext_drop_a",   int'(da), 2);
        ext = 1'b1;

        // Repeated single-cycle drops drive the counter into saturation.
        for (int i = 0; i < 620; i++) begin
            dev = ~dev;
            step(1);
        end
        dev = 1'b1;
        step(5);
        chk("sat_drop_a", int'(da), 255);
        chk("sat_drop_b", int'(db), 255);

        // Reset asserted while dut_a sits in PERIPH.
        apply_reset(2);
        step(21);
        chk("mid_pre_periph_a", int'(pa), 1);
        chk("mid_pre_fabric_a", int'(fa), 0);
        apply_reset(2);
        step(30);
        chk("resume_periph_a", rise_pa, 19);
        chk("resume_fabric_a", rise_fa, 27);
        chk("resume_drop_a",   int'(da), 0);

        // Randomized qualifier segments with occasional asynchronous resets.
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 9) == 0) begin
                apply_reset(int'($urandom_range(1, 3)));
            end else begin
                mode = int'($urandom_range(0, 7));
                len  = int'($urandom_range(1, 40));
                dev  = (mode != 0);
                xcvr = (mode != 1);
                pll  = (mode != 2);
                ext  = (mode != 3);
                step(len);
            end
        end

        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
